// File: rtl/johnson_decoder_if.sv
// Johnson decoder sample/status bundle: the master drives the code, the slave (decoder)
// returns the registered decode and health flags.
interface johnson_decoder_if #(
  parameter int N     = 4,
  parameter int IDX_W = 3
);
  logic [N-1:0]     johnson_in;
  logic             sample_en;
  logic             clr_err;
  logic [IDX_W-1:0] index;
  logic             valid;
  logic             illegal;
  logic             seq_err;
  logic             dir;
  logic             locked;
  logic [7:0]       err_count;

  modport master (
    output johnson_in, sample_en, clr_err,
    input  index, valid, illegal, seq_err, dir, locked, err_count
  );

  modport slave (
    input  johnson_in, sample_en, clr_err,
    output index, valid, illegal, seq_err, dir, locked, err_count
  );
endinterface

// File: rtl/johnson_decoder.sv
// Johnson code decoder and health monitor: decodes to a state index, classifies each step
// against the previous index and tracks lock.
//
// state       | meaning
// UNLOCKED    | no reference index; next legal code only seeds prev
// ACQUIRE     | counting consecutive good steps towards LOCK_CNT
// LOCKED      | tracking; ERR_LIMIT consecutive errors drop back to UNLOCKED
module johnson_decoder #(
  parameter int N         = 4,
  parameter int IDX_W     = 3,
  parameter int LOCK_CNT  = 4,
  parameter int ERR_LIMIT = 3
) (
  input logic              clk,
  input logic              reset,
  johnson_decoder_if.slave bus
);

  localparam int TWO_N = 2 * N;
  localparam int GW    = $clog2(LOCK_CNT + 1);
  localparam int EW    = $clog2(ERR_LIMIT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TWO_N - 1);
  localparam logic [GW-1:0]    GOOD_TOP = GW'(LOCK_CNT - 1);
  localparam logic [EW-1:0]    ERR_TOP  = EW'(ERR_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [GW-1:0]    r_good_cnt, w_good_nxt;
  logic [EW-1:0]    r_err_run, w_err_run_nxt;

  logic [IDX_W-1:0] r_index, w_index_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_illegal, w_illegal_nxt;
  logic             r_seq_err, w_seq_err_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_locked, w_locked_nxt;
  logic [7:0]       r_err_count, w_err_count_nxt;

  logic             w_legal;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_p_inc, w_p_dec;
  logic             w_fwd, w_bwd, w_stall;
  logic             w_ill_ev, w_seq_ev, w_good_ev;

  // Code for index k: k ones from the MSB for k<=N, otherwise (k-N) zeros then ones.
  function automatic logic [N-1:0] code_of(input int k);
    logic [N-1:0] c;
    c = '0;
    for (int m = 0; m < N; m++) begin
      if (k <= N) c[N-1-m] = (m < k);
      else        c[N-1-m] = (m >= k - N);
    end
    return c;
  endfunction

  always_comb begin
    w_legal = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < TWO_N; k++) begin
      if (bus.johnson_in == code_of(k)) begin
        w_legal = 1'b1;
        w_idx   = k[IDX_W-1:0];
      end
    end
  end

  // r_index doubles as the previous index: both update only on legal codes.
  assign w_p_inc = (r_index == LAST_IDX) ? '0 : r_index + 1'b1;
  assign w_p_dec = (r_index == '0) ? LAST_IDX : r_index - 1'b1;
  assign w_fwd   = (w_idx == w_p_inc);
  assign w_bwd   = (w_idx == w_p_dec);
  assign w_stall = (w_idx == r_index);

  assign w_ill_ev  = bus.sample_en & ~w_legal;
  assign w_seq_ev  = bus.sample_en & w_legal & (r_state != ST_UNLOCKED) & ~(w_fwd | w_bwd | w_stall);
  assign w_good_ev = bus.sample_en & w_legal & (r_state != ST_UNLOCKED) & (w_fwd | w_bwd);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_UNLOCKED;
      r_good_cnt <= '0;
      r_err_run  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_err_run  <= w_err_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_good_nxt    = r_good_cnt;
    w_err_run_nxt = r_err_run;
    if (bus.sample_en) begin
      case (r_state)
        ST_UNLOCKED: begin
          if (w_legal) begin
            w_state_nxt   = ST_ACQUIRE;
            w_good_nxt    = '0;
            w_err_run_nxt = '0;
          end
        end
        ST_ACQUIRE: begin
          if (w_ill_ev) begin
            w_state_nxt = ST_UNLOCKED;
            w_good_nxt  = '0;
          end else if (w_seq_ev) begin
            w_good_nxt = '0;
          end else if (w_good_ev) begin
            if (r_good_cnt == GOOD_TOP) begin
              w_state_nxt   = ST_LOCKED;
              w_good_nxt    = '0;
              w_err_run_nxt = '0;
            end else begin
              w_good_nxt = r_good_cnt + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (w_ill_ev || w_seq_ev) begin
            if (r_err_run == ERR_TOP) begin
              w_state_nxt   = ST_UNLOCKED;
              w_err_run_nxt = '0;
            end else begin
              w_err_run_nxt = r_err_run + 1'b1;
            end
          end else begin
            w_err_run_nxt = '0;
          end
        end
        default: begin
          w_state_nxt   = ST_UNLOCKED;
          w_good_nxt    = '0;
          w_err_run_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_valid_nxt   = bus.sample_en;
    w_illegal_nxt = w_ill_ev;
    w_seq_err_nxt = w_seq_ev;
    w_index_nxt   = (bus.sample_en && w_legal) ? w_idx : r_index;
    w_dir_nxt     = w_good_ev ? ~w_fwd : r_dir;
    w_locked_nxt  = (w_state_nxt == ST_LOCKED);
    w_err_count_nxt = r_err_count;
    if (bus.clr_err)
      w_err_count_nxt = '0;
    else if ((w_ill_ev || w_seq_ev) && (r_err_count != 8'hFF))
      w_err_count_nxt = r_err_count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_index     <= '0;
      r_valid     <= 1'b0;
      r_illegal   <= 1'b0;
      r_seq_err   <= 1'b0;
      r_dir       <= 1'b0;
      r_locked    <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_index     <= w_index_nxt;
      r_valid     <= w_valid_nxt;
      r_illegal   <= w_illegal_nxt;
      r_seq_err   <= w_seq_err_nxt;
      r_dir       <= w_dir_nxt;
      r_locked    <= w_locked_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  assign bus.index     = r_index;
  assign bus.valid     = r_valid;
  assign bus.illegal   = r_illegal;
  assign bus.seq_err   = r_seq_err;
  assign bus.dir       = r_dir;
  assign bus.locked    = r_locked;
  assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (N=4, LOCK_CNT=4, ERR_LIMIT=3) with hand-computed
// expected outputs after each sampling edge.
`timescale 1ns/1ps
module tb_johnson_decoder;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  johnson_decoder_if #(.N(4), .IDX_W(3)) bus ();

  johnson_decoder #(
    .N(4), .IDX_W(3), .LOCK_CNT(4), .ERR_LIMIT(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One edge: drive after the falling edge, check 1ns after the rising edge.
  task automatic step(input logic rst, input logic [3:0] code, input logic en, input logic clr);
    @(negedge clk);
    reset          = rst;
    bus.johnson_in = code;
    bus.sample_en  = en;
    bus.clr_err    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string tag, input int idx, input int v, input int ill,
                    input int se, input int d, input int lk, input int ec);
    chk({tag, ".index"},     32'(bus.index),     32'(idx));
    chk({tag, ".valid"},     32'(bus.valid),     32'(v));
    chk({tag, ".illegal"},   32'(bus.illegal),   32'(ill));
    chk({tag, ".seq_err"},   32'(bus.seq_err),   32'(se));
    chk({tag, ".dir"},       32'(bus.dir),       32'(d));
    chk({tag, ".locked"},    32'(bus.locked),    32'(lk));
    chk({tag, ".err_count"}, 32'(bus.err_count), 32'(ec));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.johnson_in = 4'b0000;
    bus.sample_en  = 1'b0;
    bus.clr_err    = 1'b0;

    // Reset held with random codes sampled.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
      ex($sformatf("rst%0d", i), 0, 0, 0, 0, 0, 0, 0);
    end

    // Forward acquire: seed then four good steps.
    step(1'b1, 4'b0000, 1'b1, 1'b0); ex("seed0", 0, 1, 0, 0, 0, 0, 0);
    step(1'b1, 4'b1000, 1'b1, 1'b0); ex("fwd1",  1, 1, 0, 0, 0, 0, 0);
    step(1'b1, 4'b1100, 1'b1, 1'b0); ex("fwd2",  2, 1, 0, 0, 0, 0, 0);
    step(1'b1, 4'b1110, 1'b1, 1'b0); ex("fwd3",  3, 1, 0, 0, 0, 0, 0);
    step(1'b1, 4'b1111, 1'b1, 1'b0); ex("fwd4",  4, 1, 0, 0, 0, 1, 0);
    step(1'b1, 4'b1010, 1'b0, 1'b0); ex("idle",  4, 0, 0, 0, 0, 1, 0);

    // Wrap forward, then reverse while locked.
    step(1'b1, 4'b0111, 1'b1, 1'b0); ex("fwd5",  5, 1, 0, 0, 0, 1, 0);
    step(1'b1, 4'b0011, 1'b1, 1'b0); ex("fwd6",  6, 1, 0, 0, 0, 1, 0);
    step(1'b1, 4'b0001, 1'b1, 1'b0); ex("fwd7",  7, 1, 0, 0, 0, 1, 0);
    step(1'b1, 4'b0000, 1'b1, 1'b0); ex("wrap0", 0, 1, 0, 0, 0, 1, 0);
    step(1'b1, 4'b0001, 1'b1, 1'b0); ex("bwd7",  7, 1, 0, 0, 1, 1, 0);
    step(1'b1, 4'b0011, 1'b1, 1'b0); ex("bwd6",  6, 1, 0, 0, 1, 1, 0);

    // Three consecutive illegal codes drop lock.
    step(1'b1, 4'b1010, 1'b1, 1'b0); ex("ill1",  6, 1, 1, 0, 1, 1, 1);
    step(1'b1, 4'b1010, 1'b1, 1'b0); ex("ill2",  6, 1, 1, 0, 1, 1, 2);
    step(1'b1, 4'b1010, 1'b1, 1'b0); ex("ill3",  6, 1, 1, 0, 1, 0, 3);
    // Non-adjacent legal code after unlock only seeds.
    step(1'b1, 4'b0000, 1'b1, 1'b0); ex("reseed", 0, 1, 0, 0, 1, 0, 3);

    // ACQUIRE: a jump clears the good count, a stall is neutral.
    step(1'b1, 4'b1000, 1'b1, 1'b0); ex("acq_g1",   1, 1, 0, 0, 0, 0, 3);
    step(1'b1, 4'b1110, 1'b1, 1'b0); ex("acq_jump", 3, 1, 0, 1, 0, 0, 4);
    step(1'b1, 4'b1110, 1'b1, 1'b0); ex("acq_stall",3, 1, 0, 0, 0, 0, 4);
    step(1'b1, 4'b1111, 1'b1, 1'b0); ex("acq_r1",   4, 1, 0, 0, 0, 0, 4);
    step(1'b1, 4'b0111, 1'b1, 1'b0); ex("acq_r2",   5, 1, 0, 0, 0, 0, 4);
    step(1'b1, 4'b0011, 1'b1, 1'b0); ex("acq_r3",   6, 1, 0, 0, 0, 0, 4);
    step(1'b1, 4'b0001, 1'b1, 1'b0); ex("acq_r4",   7, 1, 0, 0, 0, 1, 4);
    step(1'b1, 4'b0000, 1'b1, 1'b0); ex("lk_0",     0, 1, 0, 0, 0, 1, 4);
    step(1'b1, 4'b1000, 1'b1, 1'b0); ex("lk_1",     1, 1, 0, 0, 0, 1, 4);

    // Jump while locked, then clear coincident with an illegal event.
    step(1'b1, 4'b1111, 1'b1, 1'b0); ex("lk_jump",  4, 1, 0, 1, 0, 1, 5);
    step(1'b1, 4'b1010, 1'b1, 1'b1); ex("clr_ev",   4, 1, 1, 0, 0, 1, 0);
    step(1'b1, 4'b1111, 1'b1, 1'b0); ex("lk_stall", 4, 1, 0, 0, 0, 1, 0);

    // Saturation over 300 illegal samples.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 4'b1010, 1'b1, 1'b0);
      if (i == 253) chk("sat_254", 32'(bus.err_count), 32'd254);
    end
    ex("sat_end", 4, 1, 1, 0, 0, 0, 255);

    // Relock at index 5.
    step(1'b1, 4'b1000, 1'b1, 1'b0); ex("rl_seed", 1, 1, 0, 0, 0, 0, 255);
    step(1'b1, 4'b1100, 1'b1, 1'b0); ex("rl_2",    2, 1, 0, 0, 0, 0, 255);
    step(1'b1, 4'b1110, 1'b1, 1'b0); ex("rl_3",    3, 1, 0, 0, 0, 0, 255);
    step(1'b1, 4'b1111, 1'b1, 1'b0); ex("rl_4",    4, 1, 0, 0, 0, 0, 255);
    step(1'b1, 4'b0111, 1'b1, 1'b0); ex("rl_5",    5, 1, 0, 0, 0, 1, 255);

    // Reset mid-operation, then reacquire from index 5.
    step(1'b0, 4'b0011, 1'b1, 1'b0); ex("mid_rst", 0, 0, 0, 0, 0, 0, 0);
    step(1'b1, 4'b0111, 1'b1, 1'b0); ex("post_5",  5, 1, 0, 0, 0, 0, 0);
    step(1'b1, 4'b0011, 1'b1, 1'b0); ex("post_6",  6, 1, 0, 0, 0, 0, 0);
    step(1'b1, 4'b0001, 1'b1, 1'b0); ex("post_7",  7, 1, 0, 0, 0, 0, 0);
    step(1'b1, 4'b0000, 1'b1, 1'b0); ex("post_0",  0, 1, 0, 0, 0, 0, 0);
    step(1'b1, 4'b1000, 1'b1, 1'b0); ex("post_1",  1, 1, 0, 0, 0, 1, 0);

    // Illegal in ACQUIRE returns to UNLOCKED: a following jump only seeds.
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b1, 1'b0); ex("aq_seed", 0, 1, 0, 0, 0, 0, 0);
    step(1'b1, 4'b0101, 1'b1, 1'b0); ex("aq_ill",  0, 1, 1, 0, 0, 0, 1);
    step(1'b1, 4'b1111, 1'b1, 1'b0); ex("aq_re",   4, 1, 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
